// File: rtl/fetch_pkg.sv
// Shared constants, FSM state encoding and buffer entry layout for the fetch unit.
package fetch_pkg;

  localparam int unsigned INST_W        = 32;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IDLE: no request, WAIT: live request, DROP: request whose data is thrown away
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // One prefetch buffer entry
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect and decode handshake bundle of the fetch unit.
interface fetch_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with flush, occupancy count and head read-out.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer, count and storage update; flush outranks push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
      end
      if (pop) begin
        rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      end
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Head entry straight from storage
  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM, fetch PC tracking and a prefetch buffer toward decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = DEFAULT_DEPTH
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = FETCH_IDLE;
  localparam logic [1:0] WAIT = FETCH_WAIT;
  localparam logic [1:0] DROP = FETCH_DROP;
  localparam logic [ADDR_W-1:0] INST_BYTES = ADDR_W'(INST_W / 8);

  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr, req_addr_d;
  logic [ADDR_W-1:0] next_seq_pc;
  logic [CNT_W-1:0]  count;
  logic              push, pop, flush;
  logic              inst_valid;
  logic              room_after_push;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && bus.inst_ready;
  assign flush       = bus.redirect;
  assign next_seq_pc = ADDR_W'(fetch_pc + INST_BYTES);
  assign push_data   = '{pc: fetch_pc, inst: bus.imem_rdata};

  // Room for another request once this cycle's push and any pop settle
  assign room_after_push = pop ? (count < CNT_W'(DEPTH)) : (count < CNT_W'(DEPTH - 1));

  // State, fetch PC and request address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_addr <= req_addr_d;
    end
  end

  // Next-state, PC and push decisions; redirect always wins over an ack
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_addr_d = req_addr;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (count < CNT_W'(DEPTH)) begin
          state_d    = WAIT;
          req_addr_d = fetch_pc;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          state_d    = bus.imem_ack ? IDLE : DROP;
        end else if (bus.imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_seq_pc;
          if (room_after_push) begin
            req_addr_d = next_seq_pc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  // Outputs decoded from registered state and buffer head
  assign bus.imem_req   = (state != IDLE);
  assign bus.imem_addr  = req_addr;
  assign bus.inst_valid = inst_valid;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

endmodule
